// File: rtl/logic_exec_stage.sv
// logic_exec_stage: two-stage AND/OR/XOR/NOR execute stage with valid/ready flow control.
// Optional registered zero flag on y is enabled by defining LOGIC_ZERO_FLAG_EN.
module logic_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] op_count
`ifdef LOGIC_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_y;
  logic [CNT_W-1:0] r_op_count;

  logic             w_s2_ready;
  logic             w_s1_ready;
  logic             w_out_fire;
  logic [WIDTH-1:0] w_result;

  // Ready flows backwards combinationally; valid only ever moves through registers.
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  always_comb begin
    w_result = '0;
    case (r_s1_op)
      OP_AND:  w_result = r_s1_a & r_s1_b;
      OP_OR:   w_result = r_s1_a | r_s1_b;
      OP_XOR:  w_result = r_s1_a ^ r_s1_b;
      OP_NOR:  w_result = ~(r_s1_a | r_s1_b);
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_AND;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_s1_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= op_e'(op);
        r_s1_a  <= a;
        r_s1_b  <= b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y <= w_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_out_fire) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

`ifdef LOGIC_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else if (w_s2_ready && r_s1_valid) begin
      r_zero <= (w_result == '0);
    end
  end

  assign zero = r_zero;
`endif

  assign in_ready  = w_s1_ready;
  assign out_valid = r_s2_valid;
  assign y         = r_y;
  assign op_count  = r_op_count;

endmodule
